// File: rtl/cdm_pkg.sv
// Shared widths, FSM state encoding and the |exact - approx| helper for the
// cdm8 multiplier error monitor.
package cdm_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 32;
  localparam int SUM_W  = 40;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // 17-bit signed difference so R above or below the exact product is handled.
  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y);
    logic [PROD_W:0] d;
    logic [PROD_W:0] nd;
    d  = {1'b0, x} - {1'b0, y};
    nd = -d;
    return d[PROD_W] ? nd[PROD_W-1:0] : d[PROD_W-1:0];
  endfunction
endpackage

// File: rtl/cdm8_err_monitor_if.sv
// Sample handshake between the multiplier under test (master) and the monitor.
interface cdm8_err_monitor_if;
  import cdm_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic [PROD_W-1:0] in_r;
  logic              in_last;

  modport master (output in_valid, in_a, in_b, in_r, in_last, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_r, in_last, output in_ready);
endinterface

// File: rtl/cdm8_exact_ref.sv
// Pipeline stage 1: registered exact 8x8 unsigned product alongside the
// approximate result it will be compared with.
module cdm8_exact_ref
  import cdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] r,
  output logic [PROD_W-1:0] prod,
  output logic [PROD_W-1:0] r_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      r_q  <= '0;
    end else if (en) begin
      prod <= {{(PROD_W-OP_W){1'b0}}, a} * {{(PROD_W-OP_W){1'b0}}, b};
      r_q  <= r;
    end
  end
endmodule

// File: rtl/cdm8_err_monitor.sv
// Error-statistics monitor for an approximate 8x8 multiplier.
// Optional CDM_WORST_CAPTURE_EN adds worst_a/worst_b (operands of the max error).
module cdm8_err_monitor
  import cdm_pkg::*;
#(
  parameter int unsigned ERR_THRESH = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  cdm8_err_monitor_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic [PROD_W-1:0]  max_abs_err
`ifdef CDM_WORST_CAPTURE_EN
  ,
  output logic [OP_W-1:0]    worst_a,
  output logic [OP_W-1:0]    worst_b
`endif
);
  localparam int STAGES = 2;

  state_t            state;
  logic              ready;
  logic              drain_cnt;
  logic              accept;
  logic [STAGES:1]   vld_pipe;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] r_q;
  logic [PROD_W-1:0] abs_q;

  assign accept       = bus.in_valid & ready;
  assign bus.in_ready = ready;

  cdm8_exact_ref u_exact (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .a    (bus.in_a),
    .b    (bus.in_b),
    .r    (bus.in_r),
    .prod (prod_q),
    .r_q  (r_q)
  );

`ifdef CDM_WORST_CAPTURE_EN
  logic [OP_W-1:0] a1, b1, a2, b2;

  always_ff @(posedge clk) begin
    if (rst || (start && (state == ST_IDLE || state == ST_DONE))) begin
      a1 <= '0; b1 <= '0; a2 <= '0; b2 <= '0;
      worst_a <= '0; worst_b <= '0;
    end else begin
      if (accept) begin
        a1 <= bus.in_a;
        b1 <= bus.in_b;
      end
      if (vld_pipe[1]) begin
        a2 <= a1;
        b2 <= b1;
      end
      if (vld_pipe[2] && abs_q > max_abs_err) begin
        worst_a <= a2;
        worst_b <= b2;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ready        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      drain_cnt    <= 1'b0;
      vld_pipe     <= '0;
      abs_q        <= '0;
      sample_count <= '0;
      err_count    <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};

      // Stage 2 front half: error magnitude, sample counted here.
      if (vld_pipe[1]) begin
        abs_q <= abs_diff(prod_q, r_q);
        if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
      end

      if (vld_pipe[2]) begin
        sum_abs_err <= sum_abs_err + SUM_W'(abs_q);
        if (32'(abs_q) > ERR_THRESH && err_count != '1)
          err_count <= err_count + CNT_W'(1);
        if (abs_q > max_abs_err) max_abs_err <= abs_q;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_RUN;
            ready        <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            vld_pipe     <= '0;
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
          end
        end
        ST_RUN: begin
          if (accept && bus.in_last) begin
            state     <= ST_DRAIN;
            ready     <= 1'b0;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two cycles lets the last sample clear both pipeline stages.
          if (drain_cnt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cdm8_err_monitor.md
CDM8_ERR_MONITOR -- requirements
Module: cdm8_err_monitor

Interface
REQ-001 Parameter ERR_THRESH, default 0: a sample counts as erroneous only when |err| > ERR_THRESH.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse; clears statistics and opens a measurement run.
REQ-005 in_valid  input  1  sample present on in_a/in_b/in_r/in_last.
REQ-006 in_ready  output  1  monitor accepts a sample this cycle.
REQ-007 in_a, in_b  input  8 each  multiplier operands, unsigned.
REQ-008 in_r  input  16  approximate product from the multiplier under test, unsigned.
REQ-009 in_last  input  1  marks the final sample of the run.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE; statistics are stable.
REQ-012 sample_count  output  32  samples accepted in the run.
REQ-013 err_count  output  32  samples with |err| > ERR_THRESH.
REQ-014 sum_abs_err  output  40  sum of |A*B - R| over the run.
REQ-015 max_abs_err  output  16  largest |A*B - R| in the run.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE --start--> RUN; RUN --accepted sample with in_last--> DRAIN; DRAIN --2 cycles--> DONE; DONE --start--> RUN.
REQ-018 Entry into RUN on start clears all statistic outputs to 0 in the same edge.
REQ-019 in_ready is 1 only in RUN; a sample is accepted when in_valid and in_ready are both 1.
REQ-020 start in RUN or DRAIN is ignored.
REQ-021 Two-stage pipeline: stage 1 registers exact = A*B (16 bits) and R; stage 2 computes |exact - R| and updates the statistics.
REQ-022 Accumulator effects of an accepted sample are visible 2 cycles after acceptance; sample_count increments 1 cycle after acceptance.
REQ-023 done rises exactly 2 cycles after the in_last sample is accepted, with all statistics final.
REQ-024 |err| is computed in 17-bit signed arithmetic and is exact for R above or below A*B.
REQ-025 max_abs_err updates only on strict greater-than, so ties keep the earlier value.
REQ-026 sample_count and err_count saturate at 2^32-1; sum_abs_err cannot overflow for 2^24 or fewer samples, and behaviour beyond that is wrap-around.
REQ-027 The monitor has no sample-count limit; the run ends only on in_last.
REQ-028 Sample data arriving outside RUN has no effect.

Reset
REQ-029 rst has priority over start and sample handshakes.
REQ-030 On rst the state goes to IDLE; in_ready, busy and done go to 0; all statistics and pipeline valids go to 0.
REQ-031 rst in RUN or DRAIN discards in-flight pipeline samples without updating statistics.

Configuration
REQ-032 With CDM_WORST_CAPTURE_EN defined, the block adds outputs worst_a[7:0] and worst_b[7:0]; both are cleared on rst and on start, and are loaded with the operands of the sample whenever max_abs_err updates.
REQ-033 Without CDM_WORST_CAPTURE_EN, those ports and registers do not exist; all other behaviour is identical.

Structure
REQ-034 Shared package cdm_pkg holds the operand width (8), product width (16), accumulator widths (32, 40) and the FSM state enum.
REQ-035 One sub-module, cdm8_exact_ref, holds the registered exact 8x8 unsigned multiply used as stage 1.

Verification
REQ-036 Sample A=255, B=255, R=65025 with in_last -> done after 2 cycles; sample_count=1, err_count=0, sum_abs_err=0, max_abs_err=0.
REQ-037 Samples (3,3,8), then (10,10,104), then (0,7,0) with last -> err_count=2, sum_abs_err=5, max_abs_err=4, sample_count=3.
REQ-038 ERR_THRESH=1 with samples (3,3,8) and (3,3,12) -> err_count=1, sum_abs_err=4.
REQ-039 Exhaustive 65536-sample sweep with R=A*B and in_valid randomly deasserted -> all error statistics 0, sample_count=65536.
REQ-040 rst asserted 1 cycle after a sample with |err|=100 is accepted -> statistics stay 0; a following start and clean run are unaffected.
REQ-041 With CDM_WORST_CAPTURE_EN: samples (2,2,0) then (5,5,20) -> max_abs_err=5, worst_a=5, worst_b=5.
